// File: rtl/sequence_detector_moore_verilog.sv
// -----------------------------------------------------------------------------
// sequence_detector_moore_verilog
//
// Purpose:
//   Moore-style serial detector for the bit pattern 1011, first-received bit
//   first. Overlapping matches are recognised: after a full match the FSM
//   keeps whatever suffix can still start the next pattern.
//
// Ports:
//   clock        in   1  rising-edge system clock
//   reset        in   1  asynchronous, active-high; forces IDLE immediately
//   sequence_in  in   1  serial data bit, sampled on each rising clock edge
//   detector_out out  1  high only while the FSM sits in S1011
//   state_o      out  3  current state encoding, for observation/debug
//
// Interface note:
//   There is no handshake. One bit is consumed on every rising edge that has
//   reset low, and the output is valid for the whole cycle that follows.
// -----------------------------------------------------------------------------
module sequence_detector_moore_verilog (
    input  logic       clock,
    input  logic       reset,
    input  logic       sequence_in,
    output logic       detector_out,
    output logic [2:0] state_o
);

    // States are named after the prefix of 1011 matched so far.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register. Reset is asynchronous, so the output (decoded from this
    // register) drops as soon as reset rises, without waiting for an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Each arc keeps the longest suffix of the bits seen
    // so far that is still a prefix of 1011.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = sequence_in ? S1    : IDLE;
            S1:      state_d = sequence_in ? S1    : S10;
            S10:     state_d = sequence_in ? S101  : IDLE;
            S101:    state_d = sequence_in ? S1011 : S10;
            // After 1011 the trailing "1" can start a new match; a "0" makes
            // the trailing "10" the live prefix.
            S1011:   state_d = sequence_in ? S1    : S10;
            // Encodings 5..7 are unreachable; fall back to IDLE.
            default: state_d = IDLE;
        endcase
    end

    // Moore output: pure decode of the registered state, no input term, so
    // it cannot glitch between edges.
    assign detector_out = (state_q == S1011);
    assign state_o      = state_q;

endmodule

// File: tb/tb_sequence_detector_moore_verilog.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector_moore_verilog
//
// Directed, table-driven bench for the 1011 Moore detector. Inputs are driven
// 1 ns after a rising edge; outputs are checked 1 ns after the next edge.
// -----------------------------------------------------------------------------
module tb_sequence_detector_moore_verilog;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_S1    = 3'd1;
    localparam logic [2:0] ST_S10   = 3'd2;
    localparam logic [2:0] ST_S101  = 3'd3;
    localparam logic [2:0] ST_S1011 = 3'd4;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       detector_out;
    logic [2:0] state_o;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic       rst;      // pulse reset before applying this row
        logic       din;
        logic       exp_out;
        logic [2:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    sequence_detector_moore_verilog dut (
        .clock        (clock),
        .reset        (reset),
        .sequence_in  (sequence_in),
        .detector_out (detector_out),
        .state_o      (state_o)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic din, input logic exp_out, input logic [2:0] exp_st);
        vec_t v;
        v.rst     = rst;
        v.din     = din;
        v.exp_out = exp_out;
        v.exp_st  = exp_st;
        vecs.push_back(v);
    endtask

    // Called at edge+1ns; holds reset over two edges, releases at edge+1ns.
    task automatic do_reset();
        reset       = 1'b1;
        sequence_in = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Called at edge+1ns: drive bit, take one edge, return at edge+1ns.
    task automatic step(input logic din);
        sequence_in = din;
        @(posedge clock);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        reset       = 1'b0;
        sequence_in = 1'b0;

        // Basic detect: 1,0,1,1,0,0
        add(1, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);
        add(0, 0, 0, ST_S10);
        add(0, 0, 0, ST_IDLE);
        // Embedded: 0,0,1,0,1,1,0,0
        add(1, 0, 0, ST_IDLE);
        add(0, 0, 0, ST_IDLE);
        add(0, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);
        add(0, 0, 0, ST_S10);
        add(0, 0, 0, ST_IDLE);
        // Overlap: 1,0,1,1,0,1,1 -> pulses three cycles apart
        add(1, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);
        // Overlap: 1,0,1,1,1 -> one pulse
        add(1, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);
        add(0, 1, 0, ST_S1);
        // Near miss: 1,0,0,1,1
        add(1, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 0, 0, ST_IDLE);
        add(0, 1, 0, ST_S1);
        add(0, 1, 0, ST_S1);
        // Near miss: 1,1,1,1
        add(1, 1, 0, ST_S1);
        add(0, 1, 0, ST_S1);
        add(0, 1, 0, ST_S1);
        add(0, 1, 0, ST_S1);
        // 1,0,1,0,1,1 -> pulse on last bit
        add(1, 1, 0, ST_S1);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 0, 0, ST_S10);
        add(0, 1, 0, ST_S101);
        add(0, 1, 1, ST_S1011);

        // Align to edge+1ns.
        @(posedge clock);
        #1;

        // Reset held for two edges with sequence_in=0.
        reset       = 1'b1;
        sequence_in = 1'b0;
        #1;
        check("reset_async_out", {31'd0, detector_out}, 32'd0);
        check("reset_async_state", {29'd0, state_o}, {29'd0, ST_IDLE});
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check("reset_hold_out", {31'd0, detector_out}, 32'd0);
            check("reset_hold_state", {29'd0, state_o}, {29'd0, ST_IDLE});
        end
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].din);
            check($sformatf("vec%0d_out", i), {31'd0, detector_out}, {31'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_state", i), {29'd0, state_o}, {29'd0, vecs[i].exp_st});
        end

        // Async reset while in S1011, then 0,1,1 after release.
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("midrst_pre_out", {31'd0, detector_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_drop_out", {31'd0, detector_out}, 32'd0);
        check("midrst_drop_state", {29'd0, state_o}, {29'd0, ST_IDLE});
        #1;
        reset = 1'b0;
        // Still before the next edge; first sample is taken on that edge.
        sequence_in = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_0_out", {31'd0, detector_out}, 32'd0);
        check("post_rst_0_state", {29'd0, state_o}, {29'd0, ST_IDLE});
        step(1'b1);
        check("post_rst_1_out", {31'd0, detector_out}, 32'd0);
        check("post_rst_1_state", {29'd0, state_o}, {29'd0, ST_S1});
        step(1'b1);
        check("post_rst_2_out", {31'd0, detector_out}, 32'd0);
        check("post_rst_2_state", {29'd0, state_o}, {29'd0, ST_S1});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
